// File: rtl/ula_pkg.sv
// Shared opcodes and datapath width for the execute-stage ALU.
package ula_pkg;
    localparam int ULA_WIDTH = 32;

    localparam logic [3:0] ULA_AND = 4'b0000;
    localparam logic [3:0] ULA_OR  = 4'b0001;
    localparam logic [3:0] ULA_ADD = 4'b0010;
    localparam logic [3:0] ULA_SUB = 4'b0110;
    localparam logic [3:0] ULA_SLT = 4'b0111;
    localparam logic [3:0] ULA_NOR = 4'b1100;
endpackage

// File: rtl/ula_if.sv
// ALU operand/result bundle; vectors are big-endian, bit 0 is the MSB/sign.
interface ula_if import ula_pkg::*; #(
    parameter int WIDTH = ULA_WIDTH
) ();
    logic [0:3]       inputULA;
    logic [0:WIDTH-1] a;
    logic [0:WIDTH-1] b;
    logic [0:WIDTH-1] outputULA;
    logic             zero;
    logic             overflow;

    modport master (output inputULA, a, b, input outputULA, zero, overflow);
    modport slave  (input inputULA, a, b, output outputULA, zero, overflow);
endinterface

// File: rtl/ula_addsub.sv
// Shared adder/subtractor for ADD, SUB and SLT; subtraction is a + ~b + 1.
module ula_addsub import ula_pkg::*; #(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic             i_sub,
    input  logic [0:WIDTH-1] i_a,
    input  logic [0:WIDTH-1] i_b,
    output logic [0:WIDTH-1] o_sum,
    output logic             o_overflow
);
    logic [0:WIDTH-1] w_b_eff;
    logic [0:WIDTH-1] w_cin;

    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_cin   = {{(WIDTH-1){1'b0}}, i_sub};
    assign o_sum   = i_a + w_b_eff + w_cin;

    // Signed overflow: operands (after inversion) agree in sign but the sum does not.
    assign o_overflow = (i_a[0] == w_b_eff[0]) && (o_sum[0] != i_a[0]);
endmodule

// File: rtl/ula.sv
// 32-bit MIPS-style ALU with registered result, zero and overflow flags.
module ula import ula_pkg::*; #(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic  clk,
    input  logic  reset,
    ula_if.slave  bus
);
    logic             w_sub;
    logic [0:WIDTH-1] w_sum;
    logic             w_add_ovf;
    logic [0:WIDTH-1] w_result;
    logic             w_ovf;
    logic             w_zero;

    logic [0:WIDTH-1] r_result;
    logic             r_zero;
    logic             r_ovf;

    assign w_sub = (bus.inputULA == ULA_SUB) || (bus.inputULA == ULA_SLT);

    ula_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_sub      (w_sub),
        .i_a        (bus.a),
        .i_b        (bus.b),
        .o_sum      (w_sum),
        .o_overflow (w_add_ovf)
    );

    // Unknown or X codes fall to the default arm, so outputs stay defined.
    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (bus.inputULA)
            ULA_AND: w_result = bus.a & bus.b;
            ULA_OR:  w_result = bus.a | bus.b;
            ULA_ADD: begin
                w_result = w_sum;
                w_ovf    = w_add_ovf;
            end
            ULA_SUB: begin
                w_result = w_sum;
                w_ovf    = w_add_ovf;
            end
            ULA_SLT: w_result = {{(WIDTH-1){1'b0}}, w_sum[0] ^ w_add_ovf};
            ULA_NOR: w_result = ~(bus.a | bus.b);
            default: begin
                w_result = '0;
                w_ovf    = 1'b0;
            end
        endcase
    end

    assign w_zero = (w_result == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            r_result <= w_result;
            r_zero   <= w_zero;
            r_ovf    <= w_ovf;
        end
    end

    assign bus.outputULA = r_result;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_ula.sv
// Directed-vector bench for the ula ALU.
module tb_ula;
    import ula_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    ula_if #(.WIDTH(32)) bus ();

    ula #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        bus.inputULA = op;
        bus.a        = va;
        bus.b        = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(ULA_ADD, 32'd3, 32'd3);
        checks++;
        if (bus.outputULA !== 32'd0 || bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset: out=%h zero=%b ovf=%b expected 0/1/0",
                     bus.outputULA, bus.zero, bus.overflow);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_table(input string name, input logic [3:0] ops[],
                             input logic [31:0] as[], input logic [31:0] bs[],
                             input logic [31:0] exps[], input logic ovfs[]);
        for (int i = 0; i < ops.size(); i++) begin
            drive(ops[i], as[i], bs[i]);
            checks++;
            if (bus.outputULA !== exps[i] || bus.overflow !== ovfs[i] ||
                bus.zero !== (exps[i] == 32'd0)) begin
                failures++;
                $display("FAIL %s[%0d] op=%b a=%h b=%h: out=%h zero=%b ovf=%b expected %h/%b/%b",
                         name, i, ops[i], as[i], bs[i], bus.outputULA, bus.zero,
                         bus.overflow, exps[i], exps[i] == 32'd0, ovfs[i]);
            end
        end
    endtask

    task automatic test_arith();
        logic [3:0]  ops[]  = '{ULA_ADD, ULA_SUB, ULA_ADD, ULA_SUB, ULA_SUB, ULA_ADD};
        logic [31:0] as[]   = '{32'd3, 32'd3, 32'h7FFFFFFF, 32'd5, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] bs[]   = '{32'd3, 32'd1, 32'd1, 32'd5, 32'd1, 32'd1};
        logic [31:0] exps[] = '{32'd6, 32'd2, 32'h80000000, 32'd0, 32'h7FFFFFFF, 32'd0};
        logic        ovfs[] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        run_table("arith", ops, as, bs, exps, ovfs);
    endtask

    task automatic test_logic();
        logic [3:0]  ops[]  = '{ULA_AND, ULA_OR, ULA_NOR, ULA_AND, ULA_NOR};
        logic [31:0] as[]   = '{32'd3, 32'd3, 32'd0, 32'hF0F0F0F0, 32'hFFFF0000};
        logic [31:0] bs[]   = '{32'd1, 32'd1, 32'd0, 32'h0F0F0F0F, 32'h00000F0F};
        logic [31:0] exps[] = '{32'd1, 32'd3, 32'hFFFFFFFF, 32'd0, 32'h0000F0F0};
        logic        ovfs[] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_table("logic", ops, as, bs, exps, ovfs);
    endtask

    task automatic test_slt();
        logic [3:0]  ops[]  = '{ULA_SLT, ULA_SLT, ULA_SLT, ULA_SLT, ULA_SLT, ULA_SLT};
        logic [31:0] as[]   = '{32'd1, 32'd3, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd4};
        logic [31:0] bs[]   = '{32'd3, 32'd1, 32'd1, 32'd1, 32'h80000000, 32'd4};
        logic [31:0] exps[] = '{32'd1, 32'd0, 32'd1, 32'd1, 32'd0, 32'd0};
        logic        ovfs[] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_table("slt", ops, as, bs, exps, ovfs);
    endtask

    task automatic test_invalid();
        logic [3:0]  ops[]  = '{4'b1111, 4'b0011, 4'b1010};
        logic [31:0] as[]   = '{32'h7FFFFFFF, 32'd3, 32'hFFFFFFFF};
        logic [31:0] bs[]   = '{32'd1, 32'd3, 32'hFFFFFFFF};
        logic [31:0] exps[] = '{32'd0, 32'd0, 32'd0};
        logic        ovfs[] = '{1'b0, 1'b0, 1'b0};
        run_table("invalid", ops, as, bs, exps, ovfs);
    endtask

    task automatic test_mid_reset();
        drive(ULA_ADD, 32'd10, 32'd20);
        checks++;
        if (bus.outputULA !== 32'd30) begin
            failures++;
            $display("FAIL mid_reset_pre: out=%h expected %h", bus.outputULA, 32'd30);
        end
        reset = 1'b1;
        drive(ULA_ADD, 32'h7FFFFFFF, 32'd1);
        checks++;
        if (bus.outputULA !== 32'd0 || bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: out=%h zero=%b ovf=%b expected 0/1/0",
                     bus.outputULA, bus.zero, bus.overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.outputULA !== 32'h80000000 || bus.overflow !== 1'b1 || bus.zero !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_release: out=%h zero=%b ovf=%b expected 80000000/0/1",
                     bus.outputULA, bus.zero, bus.overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops[5]  = '{ULA_ADD, ULA_SUB, ULA_OR, ULA_SLT, ULA_NOR};
        logic [31:0] as[5]   = '{32'd100, 32'd7, 32'h00F0, 32'hFFFFFFFE, 32'h0000FFFF};
        logic [31:0] bs[5]   = '{32'd23, 32'd9, 32'h0F00, 32'hFFFFFFFF, 32'hFFFF0000};
        logic [31:0] exps[5] = '{32'd123, 32'hFFFFFFFE, 32'h0FF0, 32'd1, 32'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (bus.outputULA !== exps[i-1]) begin
                    failures++;
                    $display("FAIL b2b_hold[%0d]: out=%h expected %h", i, bus.outputULA, exps[i-1]);
                end
            end
            bus.inputULA = ops[i];
            bus.a        = as[i];
            bus.b        = bs[i];
            @(posedge clk);
            #1;
            checks++;
            if (bus.outputULA !== exps[i] || bus.zero !== (exps[i] == 32'd0)) begin
                failures++;
                $display("FAIL b2b[%0d]: out=%h zero=%b expected %h/%b",
                         i, bus.outputULA, bus.zero, exps[i], exps[i] == 32'd0);
            end
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.inputULA  = 4'b0000;
        bus.a         = '0;
        bus.b         = '0;
        test_reset();
        test_arith();
        test_logic();
        test_slt();
        test_invalid();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
